tt_um_rburt16_opamp_stim: RTL

Digital stimulus-and-capture companion for the 3-stage op-amp tile. It drives the op-amp input with a first-order sigma-delta bitstream that is low-passed by an external RC network. It reads the op-amp output back through an external comparator bit. It runs DC-level or ramp-threshold measurements and reports an 8-bit result on the dedicated outputs.

---
 rtl/tt_um_rburt16_opamp_stim.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tt_um_rburt16_opamp_stim.sv
`default_nettype none
// ============================================================================
// Module  : tt_um_rburt16_opamp_stim
// Brief   : Sigma-delta stimulus and comparator capture for op-amp DC/ramp
//           measurements. Define OPAMP_STIM_DITHER_EN for LFSR dithering.
// Revision: 1.0 - initial release
// ============================================================================
module tt_um_rburt16_opamp_stim #(
  parameter int SETTLE_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_oe,
  output logic [7:0] uio_out,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [1:0]  c_mode_dc     = 2'b00;
  localparam logic [1:0]  c_mode_up     = 2'b01;
  localparam logic [1:0]  c_mode_down   = 2'b10;
  localparam logic [1:0]  c_mode_free   = 2'b11;
  localparam logic [15:0] c_settle_last = 16'(SETTLE_CYC - 1);

  state_t      r_state;
  logic [1:0]  r_mode;
  logic [7:0]  r_level;
  logic [7:0]  r_hit;
  logic [7:0]  r_meas_cnt;
  logic [7:0]  r_result;
  logic [15:0] r_settle_cnt;
  logic [8:0]  r_acc;
  logic        r_start_s1, r_start_s2, r_start_d;
  logic        r_comp_s1, r_comp_s2;
  logic        r_busy, r_done, r_no_trip;

  logic        w_start_edge;
  logic        w_dither;
  logic        w_tripped;
  logic        w_at_end;
  logic [7:0]  w_hit_sum;
  logic        w_unused;

  assign w_start_edge = r_start_s2 & ~r_start_d;
  assign w_hit_sum    = (r_hit == 8'hFF) ? r_hit : r_hit + {7'd0, r_comp_s2};
  assign w_tripped    = w_hit_sum[7];
  assign w_at_end     = (r_mode == c_mode_up) ? (r_level == 8'hFF) : (r_level == 8'h00);
  assign w_unused     = &{1'b0, ena, uio_in[7:4]};

`ifdef OPAMP_STIM_DITHER_EN
  localparam logic [7:0] c_lfsr_taps = 8'hB8;
  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? c_lfsr_taps : 8'h00);
    end
  end

  assign w_dither = r_lfsr[0];
`else
  assign w_dither = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= c_mode_dc;
      r_level      <= 8'h00;
      r_hit        <= 8'h00;
      r_meas_cnt   <= 8'h00;
      r_result     <= 8'h00;
      r_settle_cnt <= 16'h0000;
      r_acc        <= 9'h000;
      r_start_s1   <= 1'b0;
      r_start_s2   <= 1'b0;
      r_start_d    <= 1'b0;
      r_comp_s1    <= 1'b0;
      r_comp_s2    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_no_trip    <= 1'b0;
    end else begin
      r_start_s1 <= uio_in[0];
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_comp_s1  <= uio_in[3];
      r_comp_s2  <= r_comp_s1;
      r_acc      <= {1'b0, r_acc[7:0]} + {1'b0, r_level} + {8'd0, w_dither};

      case (r_state)
        S_IDLE, S_DONE: begin
          // First DONE cycle publishes the result so done and uo_out rise together.
          if (r_state == S_DONE && !r_done) begin
            r_done    <= 1'b1;
            r_result  <= (r_mode == c_mode_dc) ? r_hit : r_level;
            r_no_trip <= (r_mode != c_mode_dc) && !r_hit[7];
          end else if (w_start_edge) begin
            r_state      <= S_SETTLE;
            r_mode       <= uio_in[2:1];
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_no_trip    <= 1'b0;
            r_hit        <= 8'h00;
            r_settle_cnt <= 16'h0000;
            case (uio_in[2:1])
              c_mode_up:   r_level <= 8'h00;
              c_mode_down: r_level <= 8'hFF;
              default:     r_level <= ui_in;
            endcase
          end
        end
        S_SETTLE: begin
          if (r_mode == c_mode_free) begin
            r_level <= ui_in;
            if (!r_start_s2) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_settle_cnt == c_settle_last) begin
            r_state    <= S_MEASURE;
            r_meas_cnt <= 8'h00;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        S_MEASURE: begin
          r_hit      <= w_hit_sum;
          r_meas_cnt <= r_meas_cnt + 8'd1;
          if (r_meas_cnt == 8'hFF) begin
            if (r_mode == c_mode_dc || w_tripped || w_at_end) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end else begin
              r_level      <= (r_mode == c_mode_up) ? r_level + 8'd1 : r_level - 8'd1;
              r_hit        <= 8'h00;
              r_settle_cnt <= 16'h0000;
              r_state      <= S_SETTLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uo_out  = r_result;
  assign uio_out = {r_no_trip, r_done, r_busy, r_acc[8], 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
`default_nettype wire
